// File: rtl/vc_sram_fifo_ctrl_if.sv
// Bundled enqueue, dequeue and SRAM-port signals of the SRAM-backed val/rdy FIFO controller.
// master = the controller itself, slave = the producer/consumer/SRAM environment.
interface vc_sram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_WORDS  = 16
);
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS);
    localparam int CNT_WIDTH  = $clog2(NUM_WORDS + 3);

    logic                  enq_val;
    logic                  enq_rdy;
    logic [DATA_WIDTH-1:0] enq_msg;
    logic                  deq_val;
    logic                  deq_rdy;
    logic [DATA_WIDTH-1:0] deq_msg;
    logic [DATA_WIDTH-1:0] sram_data_in;
    logic [ADDR_WIDTH-1:0] sram_wraddress;
    logic                  sram_wren;
    logic [ADDR_WIDTH-1:0] sram_rdaddress;
    logic [DATA_WIDTH-1:0] sram_data_out;
    logic [CNT_WIDTH-1:0]  count;

    modport master (
        input  enq_val, enq_msg, deq_rdy, sram_data_out,
        output enq_rdy, deq_val, deq_msg, sram_data_in, sram_wraddress,
               sram_wren, sram_rdaddress, count
    );

    modport slave (
        output enq_val, enq_msg, deq_rdy, sram_data_out,
        input  enq_rdy, deq_val, deq_msg, sram_data_in, sram_wraddress,
               sram_wren, sram_rdaddress, count
    );
endinterface

// File: rtl/vc_sram_fifo_ctrl.sv
// Val/rdy FIFO controller over a 1R1W synchronous SRAM with a 2-entry output buffer hiding read latency.
// Optional macro VC_SRAM_FIFO_BYPASS_EN: enqueue straight into the output buffer when the SRAM path is empty.
module vc_sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_WORDS  = 16
) (
    input  logic               clk,
    input  logic               reset,
    vc_sram_fifo_ctrl_if.master io
);
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS);
    localparam int CNT_WIDTH  = $clog2(NUM_WORDS + 3);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(NUM_WORDS);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  sram_cnt_q, sram_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] obuf_q [2];
    logic [DATA_WIDTH-1:0] obuf_d [2];
    logic                  obuf_head_q, obuf_head_d;
    logic [1:0]            obuf_cnt_q, obuf_cnt_d;

    logic                  enq_rdy;
    logic                  enq_fire;
    logic                  deq_val;
    logic                  deq_fire;
    logic                  bypass;
    logic                  sram_wren;
    logic                  issue;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  tail;
    logic [1:0]            obuf_after_pop;
    logic [2:0]            pending;

    // enq_rdy is forced low while reset is held so nothing is accepted during reset.
    assign enq_rdy        = !reset && (sram_cnt_q != FULL_CNT);
    assign enq_fire       = io.enq_val && enq_rdy;
    assign deq_val        = (obuf_cnt_q != 2'd0);
    assign deq_fire       = deq_val && io.deq_rdy;
    assign obuf_after_pop = obuf_cnt_q - {1'b0, deq_fire};
    assign pending        = {1'b0, obuf_after_pop} + {2'b00, inflight_q};
    assign issue          = (sram_cnt_q != '0) && (pending < 3'd2);

`ifdef VC_SRAM_FIFO_BYPASS_EN
    assign bypass = enq_fire && (sram_cnt_q == '0) && !inflight_q && (obuf_after_pop != 2'd2);
`else
    assign bypass = 1'b0;
`endif

    assign sram_wren = enq_fire && !bypass;
    assign push      = inflight_q || bypass;
    assign push_data = bypass ? io.enq_msg : io.sram_data_out;
    // Slot index head+cnt (mod 2) stays correct even when a pop frees the head in the same cycle.
    assign tail      = obuf_head_q ^ obuf_cnt_q[0];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        obuf_d      = obuf_q;
        inflight_d  = issue;
        obuf_head_d = obuf_head_q ^ deq_fire;
        obuf_cnt_d  = obuf_after_pop + {1'b0, push};
        sram_cnt_d  = sram_cnt_q + CNT_WIDTH'(sram_wren) - CNT_WIDTH'(issue);
        if (sram_wren) begin
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (issue) begin
            rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push) begin
            obuf_d[tail] = push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            sram_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            obuf_q      <= '{default: '0};
            obuf_head_q <= 1'b0;
            obuf_cnt_q  <= 2'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sram_cnt_q  <= sram_cnt_d;
            inflight_q  <= inflight_d;
            obuf_q      <= obuf_d;
            obuf_head_q <= obuf_head_d;
            obuf_cnt_q  <= obuf_cnt_d;
        end
    end

    assign io.enq_rdy        = enq_rdy;
    assign io.deq_val        = deq_val;
    assign io.deq_msg        = obuf_q[obuf_head_q];
    assign io.sram_data_in   = io.enq_msg;
    assign io.sram_wraddress = wr_ptr_q;
    assign io.sram_wren      = sram_wren;
    assign io.sram_rdaddress = rd_ptr_q;
    assign io.count          = sram_cnt_q + CNT_WIDTH'(inflight_q) + CNT_WIDTH'(obuf_cnt_q);
endmodule

// File: tb/tb_vc_sram_fifo_ctrl.sv
// Directed bench for vc_sram_fifo_ctrl with a behavioural 1-cycle-read SRAM and a FIFO scoreboard.
// Latency expectations follow VC_SRAM_FIFO_BYPASS_EN when it is defined.
module tb_vc_sram_fifo_ctrl;
    localparam int DW = 12;
    localparam int NW = 16;
`ifdef VC_SRAM_FIFO_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    int            check_count = 0;
    int            fail_count = 0;
    logic [DW-1:0] sram_mem [NW];
    logic [DW-1:0] sram_rd_data;
    logic [DW-1:0] sb_q [$];
    int            accepted;
    int            deq_seen;
    int            sent;
    int            guard;
    bit            seen;

    vc_sram_fifo_ctrl_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) io ();

    vc_sram_fifo_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.master)
    );

    always #5 clk = ~clk;

    assign io.sram_data_out = sram_rd_data;

    always @(posedge clk) begin
        if (io.sram_wren) sram_mem[io.sram_wraddress] <= io.sram_data_in;
        sram_rd_data <= sram_mem[io.sram_rdaddress];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs change just after the falling edge; outputs are settled and sampled 1ns later.
    task automatic applyStimulus(input logic ev, input logic [DW-1:0] msg, input logic dr);
        @(negedge clk);
        io.enq_val = ev;
        io.enq_msg = msg;
        io.deq_rdy = dr;
        #1;
    endtask

    task automatic trackFires();
        if (io.enq_val && io.enq_rdy) sb_q.push_back(io.enq_msg);
        if (io.deq_val && io.deq_rdy) begin
            if (sb_q.size() == 0) checkOutput("deq_unexpected", 32'(io.deq_val), 32'd0);
            else checkOutput("deq_msg", 32'(io.deq_msg), 32'(sb_q.pop_front()));
        end
    endtask

    initial begin
        io.enq_val = 1'b1;
        io.enq_msg = 12'h123;
        io.deq_rdy = 1'b1;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_enq_rdy", 32'(io.enq_rdy), 32'd0);
        checkOutput("rst_deq_val", 32'(io.deq_val), 32'd0);
        checkOutput("rst_wren", 32'(io.sram_wren), 32'd0);
        checkOutput("rst_count", 32'(io.count), 32'd0);
        checkOutput("rst_deq_msg", 32'(io.deq_msg), 32'd0);
        checkOutput("rst_rdaddr", 32'(io.sram_rdaddress), 32'd0);
        checkOutput("rst_wraddr", 32'(io.sram_wraddress), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        io.enq_val = 1'b0;
        #1;
        checkOutput("post_rst_enq_rdy", 32'(io.enq_rdy), 32'd1);

        // Single message latency and count profile.
        applyStimulus(1'b1, 12'hABC, 1'b1);
        checkOutput("single_wren", 32'(io.sram_wren), 32'(LAT == 3));
        checkOutput("single_count0", 32'(io.count), 32'd0);
        trackFires();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("single_deq_val_t%0d", k), 32'(io.deq_val), 32'(k == LAT));
            checkOutput($sformatf("single_count_t%0d", k), 32'(io.count), 32'(k <= LAT));
            if (k == LAT) checkOutput("single_msg", 32'(io.deq_msg), 32'hABC);
            trackFires();
        end

        // Fill with the consumer stalled: 16 in SRAM plus 2 in the output buffer.
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b0);
            if (io.enq_rdy) accepted++;
            trackFires();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("fill_accepted", 32'(accepted), 32'd18);
        checkOutput("fill_enq_rdy", 32'(io.enq_rdy), 32'd0);
        checkOutput("fill_count", 32'(io.count), 32'd18);
        checkOutput("fill_head", 32'(io.deq_msg), 32'd0);

        // Enqueue and dequeue together while full: only the dequeue fires.
        applyStimulus(1'b1, 12'h3FF, 1'b1);
        checkOutput("full_deq_val", 32'(io.deq_val), 32'd1);
        checkOutput("full_enq_rdy", 32'(io.enq_rdy), 32'd0);
        checkOutput("full_wren", 32'(io.sram_wren), 32'd0);
        trackFires();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("after_full_enq_rdy", 32'(io.enq_rdy), 32'd1);
        checkOutput("after_full_count", 32'(io.count), 32'd17);
        guard = 0;
        while (sb_q.size() > 0 && guard < 40) begin
            checkOutput("drain_deq_val", 32'(io.deq_val), 32'd1);
            trackFires();
            applyStimulus(1'b0, '0, 1'b1);
            guard++;
        end
        checkOutput("drain_empty", 32'(sb_q.size()), 32'd0);
        checkOutput("drain_count", 32'(io.count), 32'd0);

        // Streaming with both sides always ready; pointers wrap several times.
        deq_seen = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, DW'(12'h100 + i), 1'b1);
            checkOutput("stream_count", 32'(io.count), 32'(sb_q.size()));
            if (io.deq_val) deq_seen++;
            trackFires();
        end
        checkOutput("stream_throughput", 32'(deq_seen), 32'(100 - LAT));
        guard = 0;
        while (sb_q.size() > 0 && guard < 40) begin
            applyStimulus(1'b0, '0, 1'b1);
            trackFires();
            guard++;
        end
        checkOutput("stream_drained", 32'(sb_q.size()), 32'd0);

        // Random 50% backpressure on both sides.
        sent = 0;
        guard = 0;
        while ((sent < 1000 || sb_q.size() > 0) && guard < 20000) begin
            applyStimulus((sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0, DW'(sent), 1'($urandom_range(0, 1)));
            checkOutput("rand_count", 32'(io.count), 32'(sb_q.size()));
            checkOutput("rand_wren_when_full", 32'(io.sram_wren && !io.enq_rdy), 32'd0);
            if (io.enq_val && io.enq_rdy) sent++;
            trackFires();
            guard++;
        end
        checkOutput("rand_sent", 32'(sent), 32'd1000);
        checkOutput("rand_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset with seven messages held.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, DW'(12'h200 + i), 1'b0);
            trackFires();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("pre_reset_count", 32'(io.count), 32'd7);
        io.enq_val = 1'b1;
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_deq_val", 32'(io.deq_val), 32'd0);
        checkOutput("mid_rst_enq_rdy", 32'(io.enq_rdy), 32'd0);
        checkOutput("mid_rst_wren", 32'(io.sram_wren), 32'd0);
        checkOutput("mid_rst_count", 32'(io.count), 32'd0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        io.enq_val = 1'b0;
        applyStimulus(1'b1, 12'h055, 1'b1);
        trackFires();
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (io.deq_val) begin
                seen = 1'b1;
                checkOutput("post_reset_first", 32'(io.deq_msg), 32'h055);
            end
            trackFires();
        end
        checkOutput("post_reset_seen", 32'(seen), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end
endmodule
